// File: rtl/pwm_capture_if.sv
// Capture-side bundle: enable and PWM pin in, decoded duty and period/high
// measurements plus status flags out.
interface pwm_capture_if #(
  parameter int N = 4,
  parameter int M = 7
);
  logic         ena;
  logic         pwm_in;
  logic [N-1:0] duty;
  logic         duty_valid;
  logic [M-1:0] high_ticks;
  logic [M-1:0] period_ticks;
  logic         stuck;
  logic         overrun;

  modport master (
    output ena, pwm_in,
    input  duty, duty_valid, high_ticks, period_ticks, stuck, overrun
  );

  modport slave (
    input  ena, pwm_in,
    output duty, duty_valid, high_ticks, period_ticks, stuck, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a synchronized PWM input and
// reduces them to an N-bit duty code with a serial restoring divider.
module pwm_capture #(
  parameter int N = 4,
  parameter int M = 7
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.slave   bus
);

  localparam int            CW        = $clog2(N + 1);
  localparam logic [M-1:0]  MAX_TICKS = '1;
  localparam logic [M-1:0]  ONE_TICK  = M'(1);
  localparam logic [N-1:0]  MAX_DUTY  = '1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);
  localparam logic [CW-1:0] ONE_BIT   = CW'(1);

  typedef enum logic [1:0] {IDLE, ARMED, DIV, STUCK} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [M-1:0]  per_cnt, hi_cnt;
  logic [M-1:0]  p_lat, h_lat;
  logic [M:0]    rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] bit_cnt;
  logic          clamp, discard;

  logic          rise;
  logic [M:0]    shifted;
  logic          fits;
  logic [N-1:0]  quo_next;

  assign rise     = s2 & ~s3;
  assign shifted  = {rem[M-1:0], 1'b0};
  assign fits     = (shifted >= {1'b0, p_lat});
  assign quo_next = N'({quo, fits});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Both counters restart at 1 on a rise because s2 is already high that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!bus.ena) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= ONE_TICK;
      hi_cnt  <= ONE_TICK;
    end else begin
      if (per_cnt != MAX_TICKS)
        per_cnt <= per_cnt + ONE_TICK;
      if (s2 && (hi_cnt != MAX_TICKS))
        hi_cnt <= hi_cnt + ONE_TICK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      p_lat            <= '0;
      h_lat            <= '0;
      rem              <= '0;
      quo              <= '0;
      bit_cnt          <= '0;
      clamp            <= 1'b0;
      discard          <= 1'b0;
      bus.duty         <= '0;
      bus.duty_valid   <= 1'b0;
      bus.high_ticks   <= '0;
      bus.period_ticks <= '0;
      bus.stuck        <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.duty_valid <= 1'b0;
      if (!bus.ena) begin
        state       <= IDLE;
        bus.overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise)
              state <= ARMED;
          end
          ARMED: begin
            if (rise) begin
              p_lat   <= per_cnt;
              h_lat   <= hi_cnt;
              rem     <= {1'b0, hi_cnt};
              quo     <= '0;
              bit_cnt <= '0;
              clamp   <= (hi_cnt >= per_cnt);
              discard <= 1'b0;
              state   <= DIV;
            end else if (per_cnt == MAX_TICKS) begin
              state            <= STUCK;
              bus.stuck        <= 1'b1;
              bus.duty         <= s2 ? MAX_DUTY : '0;
              bus.high_ticks   <= s2 ? MAX_TICKS : '0;
              bus.period_ticks <= MAX_TICKS;
              bus.duty_valid   <= 1'b1;
            end
          end
          DIV: begin
            // The low N dividend bits are zero, so only zeros shift in.
            rem     <= fits ? (shifted - {1'b0, p_lat}) : shifted;
            quo     <= quo_next;
            bit_cnt <= bit_cnt + ONE_BIT;
            if (rise) begin
              discard     <= 1'b1;
              bus.overrun <= 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
              state <= ARMED;
              if (!(discard || rise)) begin
                bus.duty         <= clamp ? MAX_DUTY : quo_next;
                bus.high_ticks   <= h_lat;
                bus.period_ticks <= p_lat;
                bus.duty_valid   <= 1'b1;
              end
            end
          end
          STUCK: begin
            if (rise) begin
              bus.stuck <= 1'b0;
              state     <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: decodes, stuck detection, overrun,
// enable and mid-divide reset behaviour against hand-computed values.
module tb_pwm_capture;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   n_strobe;
  int   strobe_cyc;
  int   prev_strobe_cyc;
  int   stuck_cyc;
  logic stuck_seen;
  int   last_rise_cyc;
  int   n_snap;

  pwm_capture_if #(.N(4), .M(7)) bus ();

  pwm_capture #(.N(4), .M(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    n_strobe        = 0;
    strobe_cyc      = 0;
    prev_strobe_cyc = 0;
    stuck_cyc       = 0;
    stuck_seen      = 1'b0;
  end

  // Strobe and stuck-onset bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.duty_valid === 1'b1) begin
      n_strobe++;
      prev_strobe_cyc = strobe_cyc;
      strobe_cyc      = cyc;
    end
    if ((bus.stuck === 1'b1) && !stuck_seen)
      stuck_cyc = cyc;
    stuck_seen = (bus.stuck === 1'b1);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      bus.pwm_in    = 1'b1;
      last_rise_cyc = cyc;
      waitCycles(hi);
      bus.pwm_in = 1'b0;
      waitCycles(lo);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.ena    = 1'b1;
    bus.pwm_in = 1'b0;
    waitCycles(3);
    checkOutput("rst_duty", int'(bus.duty), 0);
    checkOutput("rst_valid", int'(bus.duty_valid), 0);
    checkOutput("rst_period", int'(bus.period_ticks), 0);
    checkOutput("rst_high", int'(bus.high_ticks), 0);
    checkOutput("rst_stuck", int'(bus.stuck), 0);
    checkOutput("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b1;
    waitCycles(5);

    // 30/120: first rise only arms, the second reports
    applyStimulus(30, 90, 1);
    checkOutput("first_no_strobe", n_strobe, 0);
    applyStimulus(30, 90, 2);
    checkOutput("a_strobes", n_strobe, 2);
    checkOutput("a_duty", int'(bus.duty), 4);
    checkOutput("a_high", int'(bus.high_ticks), 30);
    checkOutput("a_period", int'(bus.period_ticks), 120);
    checkOutput("a_latency", strobe_cyc - last_rise_cyc, 7);
    checkOutput("a_spacing", strobe_cyc - prev_strobe_cyc, 120);

    applyStimulus(90, 30, 2);
    checkOutput("b_duty", int'(bus.duty), 12);
    checkOutput("b_high", int'(bus.high_ticks), 90);
    applyStimulus(1, 119, 2);
    checkOutput("c_duty", int'(bus.duty), 0);
    checkOutput("c_high", int'(bus.high_ticks), 1);
    applyStimulus(119, 1, 2);
    checkOutput("d_duty", int'(bus.duty), 15);
    checkOutput("d_period", int'(bus.period_ticks), 120);

    // Held low
    n_snap     = n_strobe;
    bus.pwm_in = 1'b0;
    waitCycles(200);
    checkOutput("sl_stuck", int'(bus.stuck), 1);
    checkOutput("sl_duty", int'(bus.duty), 0);
    checkOutput("sl_period", int'(bus.period_ticks), 127);
    checkOutput("sl_high", int'(bus.high_ticks), 0);
    checkOutput("sl_one_strobe", n_strobe - n_snap, 1);
    checkOutput("sl_onset", stuck_cyc - last_rise_cyc, 130);
    n_snap = n_strobe;
    applyStimulus(30, 90, 1);
    checkOutput("sl_cleared", int'(bus.stuck), 0);
    checkOutput("sl_clear_nostrobe", n_strobe - n_snap, 0);
    applyStimulus(30, 90, 1);
    checkOutput("sl_resume_strobe", n_strobe - n_snap, 1);
    checkOutput("sl_resume_duty", int'(bus.duty), 4);

    // Held high
    bus.pwm_in    = 1'b1;
    last_rise_cyc = cyc;
    waitCycles(200);
    checkOutput("sh_stuck", int'(bus.stuck), 1);
    checkOutput("sh_duty", int'(bus.duty), 15);
    checkOutput("sh_high", int'(bus.high_ticks), 127);
    checkOutput("sh_period", int'(bus.period_ticks), 127);
    checkOutput("sh_onset", stuck_cyc - last_rise_cyc, 130);
    bus.pwm_in = 1'b0;
    waitCycles(10);
    applyStimulus(30, 90, 2);
    checkOutput("sh_cleared", int'(bus.stuck), 0);
    checkOutput("sh_resume_duty", int'(bus.duty), 4);

    // 4-clock periods are too short to decode
    applyStimulus(2, 2, 3);
    n_snap = n_strobe;
    applyStimulus(2, 2, 20);
    checkOutput("short_no_strobe", n_strobe - n_snap, 0);
    checkOutput("short_overrun", int'(bus.overrun), 1);
    n_snap = n_strobe;
    applyStimulus(30, 90, 3);
    checkOutput("ovr_sticky", int'(bus.overrun), 1);
    checkOutput("ovr_back_strobes", n_strobe - n_snap, 2);
    checkOutput("ovr_back_duty", int'(bus.duty), 4);

    // Enable pulse clears overrun, holds results, restarts from idle
    bus.ena = 1'b0;
    waitCycles(3);
    checkOutput("ena_ovr_clear", int'(bus.overrun), 0);
    checkOutput("ena_duty_hold", int'(bus.duty), 4);
    checkOutput("ena_period_hold", int'(bus.period_ticks), 120);
    bus.ena = 1'b1;
    n_snap  = n_strobe;
    applyStimulus(90, 30, 1);
    checkOutput("ena_first_nostrobe", n_strobe - n_snap, 0);
    applyStimulus(90, 30, 1);
    checkOutput("ena_resume_strobe", n_strobe - n_snap, 1);
    checkOutput("ena_resume_duty", int'(bus.duty), 12);

    // Reset two clocks after the latching rise, mid-divide
    bus.pwm_in    = 1'b1;
    last_rise_cyc = cyc;
    waitCycles(5);
    n_snap = n_strobe;
    rst    = 1'b0;
    #1;
    checkOutput("mrst_duty", int'(bus.duty), 0);
    checkOutput("mrst_period", int'(bus.period_ticks), 0);
    checkOutput("mrst_high", int'(bus.high_ticks), 0);
    checkOutput("mrst_valid", int'(bus.duty_valid), 0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(23);
    bus.pwm_in = 1'b0;
    waitCycles(90);
    checkOutput("mrst_no_strobe", n_strobe - n_snap, 0);
    applyStimulus(30, 90, 2);
    checkOutput("mrst_resume_duty", int'(bus.duty), 4);
    checkOutput("mrst_resume_period", int'(bus.period_ticks), 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
